// File: rtl/pru_port_tx_pkg.sv
// Definitions shared by the PRU port egress path and its FIFO: FSM states and default widths.
package pru_port_tx_pkg;

  localparam int PRU_PW_DEF = 128;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DROP = 2'd2
  } pru_state_e;

  // Width of a counter that must hold values 0..n-1; never narrower than one bit.
  function automatic int pru_cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pru_sync_fifo.sv
// Synchronous FIFO with a registered head; the head on dout is valid whenever the FIFO is not empty.
module pru_sync_fifo
  import pru_port_tx_pkg::*;
#(
  parameter int PW    = PRU_PW_DEF,
  parameter int DEPTH = 4
) (
  input  logic                       iClk,
  input  logic                       iRstn,
  input  logic                       push,
  input  logic [PW-1:0]              din,
  input  logic                       pop,
  output logic [PW-1:0]              dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [PW-1:0] mem_q [DEPTH];
  logic [PW-1:0] mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          push_ok, pop_ok;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q];
  assign cnt     = cnt_q;

  // Pointers are exactly log2(DEPTH) bits, so they wrap without explicit compare.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (push_ok && !pop_ok) begin
      cnt_d = cnt_q + CW'(1);
    end else if (pop_ok && !push_ok) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/pru_port_tx.sv
// PRU port egress: buffers arbitrated packets and presents them to the device with a
// valid/ack handshake; a device that never acks has its head packet dropped after TMO cycles.
module pru_port_tx
  import pru_port_tx_pkg::*;
#(
  parameter int PW    = PRU_PW_DEF,
  parameter int DEPTH = 4,
  parameter int TMO   = 256
) (
  input  logic                       iClk,
  input  logic                       iRstn,
  input  logic                       arbOut_portTx_vld,
  input  logic [PW-1:0]              arbOut_portTx_pkt,
  output logic                       portTx_arbOut_ack,
  output logic                       oPort_vld,
  output logic [PW-1:0]              oPort_pkt,
  input  logic                       iPort_ack,
  output logic                       oTmoErr,
  output logic [$clog2(DEPTH+1)-1:0] oFifoCnt
);

  localparam int            TW       = pru_cnt_w(TMO);
  localparam logic [TW-1:0] TMO_LAST = TW'((TMO > 0) ? TMO - 1 : 0);

  pru_state_e    state_q, state_d;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          vld_q, vld_d;
  logic [PW-1:0] pkt_q, pkt_d;

  logic          fifo_full, fifo_empty, fifo_pop;
  logic [PW-1:0] fifo_head;

  assign portTx_arbOut_ack = arbOut_portTx_vld && !fifo_full;
  assign oPort_vld         = vld_q;
  assign oPort_pkt         = pkt_q;
  assign oTmoErr           = (state_q == ST_DROP);

  pru_sync_fifo #(
    .PW    (PW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .iClk  (iClk),
    .iRstn (iRstn),
    .push  (portTx_arbOut_ack),
    .din   (arbOut_portTx_pkt),
    .pop   (fifo_pop),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .cnt   (oFifoCnt)
  );

  always_comb begin
    state_d   = state_q;
    tmo_cnt_d = tmo_cnt_q;
    vld_d     = vld_q;
    pkt_d     = pkt_q;
    fifo_pop  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          pkt_d     = fifo_head;
          vld_d     = 1'b1;
          tmo_cnt_d = '0;
          state_d   = ST_SEND;
        end
      end
      ST_SEND: begin
        // An ack on the terminal timeout cycle is checked first, so it wins over the drop.
        if (iPort_ack) begin
          tmo_cnt_d = '0;
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            pkt_d    = fifo_head;
          end else begin
            vld_d   = 1'b0;
            state_d = ST_IDLE;
          end
        end else if ((TMO != 0) && (tmo_cnt_q == TMO_LAST)) begin
          vld_d     = 1'b0;
          tmo_cnt_d = '0;
          state_d   = ST_DROP;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TW'(1);
        end
      end
      ST_DROP: begin
        state_d = ST_IDLE;
      end
      default: begin
        vld_d     = 1'b0;
        tmo_cnt_d = '0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      state_q   <= ST_IDLE;
      tmo_cnt_q <= '0;
      vld_q     <= 1'b0;
      pkt_q     <= '0;
    end else begin
      state_q   <= state_d;
      tmo_cnt_q <= tmo_cnt_d;
      vld_q     <= vld_d;
      pkt_q     <= pkt_d;
    end
  end

endmodule

// File: tb/tb_pru_port_tx.sv
// Randomized bench for pru_port_tx against a queue-based reference model of the egress port.
module tb_pru_port_tx;

  localparam int PW    = 32;
  localparam int DEPTH = 4;
  localparam int TMO   = 8;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          iClk = 1'b0;
  logic          iRstn;
  logic          arbOut_portTx_vld;
  logic [PW-1:0] arbOut_portTx_pkt;
  logic          portTx_arbOut_ack;
  logic          oPort_vld;
  logic [PW-1:0] oPort_pkt;
  logic          iPort_ack;
  logic          oTmoErr;
  logic [CW-1:0] oFifoCnt;

  always #5 iClk = ~iClk;

  pru_port_tx #(
    .PW    (PW),
    .DEPTH (DEPTH),
    .TMO   (TMO)
  ) dut (
    .iClk              (iClk),
    .iRstn             (iRstn),
    .arbOut_portTx_vld (arbOut_portTx_vld),
    .arbOut_portTx_pkt (arbOut_portTx_pkt),
    .portTx_arbOut_ack (portTx_arbOut_ack),
    .oPort_vld         (oPort_vld),
    .oPort_pkt         (oPort_pkt),
    .iPort_ack         (iPort_ack),
    .oTmoErr           (oTmoErr),
    .oFifoCnt          (oFifoCnt)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h at t=%0t", tag, act, exp, $time);
  endtask

  // Reference model: queued packets, the packet on the wire, how long it has waited,
  // and whether this cycle is the one-cycle drop notification.
  logic [PW-1:0] m_fifo[$];
  bit            m_pres;
  logic [PW-1:0] m_pkt;
  int            m_age;
  bit            m_err;

  task automatic model_reset();
    m_fifo.delete();
    m_pres = 1'b0;
    m_pkt  = '0;
    m_age  = 0;
    m_err  = 1'b0;
  endtask

  task automatic check_cycle();
    check_eq("in_ack", portTx_arbOut_ack, arbOut_portTx_vld && (m_fifo.size() < DEPTH));
    check_eq("out_vld", oPort_vld, m_pres);
    if (m_pres) check_eq("out_pkt", oPort_pkt, m_pkt);
    check_eq("tmo_err", oTmoErr, m_err);
    check_eq("fifo_cnt", oFifoCnt, m_fifo.size());
  endtask

  task automatic model_step();
    bit push;
    bit have;
    push = arbOut_portTx_vld && (m_fifo.size() < DEPTH);
    have = (m_fifo.size() > 0);
    if (m_err) begin
      m_err = 1'b0;
    end else if (m_pres) begin
      if (iPort_ack) begin
        if (have) begin
          m_pkt = m_fifo.pop_front();
          m_age = 0;
        end else begin
          m_pres = 1'b0;
        end
      end else if (m_age == TMO - 1) begin
        m_pres = 1'b0;
        m_err  = 1'b1;
        m_age  = 0;
      end else begin
        m_age++;
      end
    end else if (have) begin
      m_pkt  = m_fifo.pop_front();
      m_pres = 1'b1;
      m_age  = 0;
    end
    if (push) m_fifo.push_back(arbOut_portTx_pkt);
  endtask

  // pv/pa: percent chance of offering a packet / acking; ack_last acks only on the final timeout cycle.
  task automatic run(input int ncyc, input int pv, input int pa, input bit ack_last);
    for (int c = 0; c < ncyc; c++) begin
      arbOut_portTx_vld = ($urandom_range(99) < pv);
      arbOut_portTx_pkt = $urandom();
      if (ack_last) iPort_ack = m_pres && (m_age == TMO - 1);
      else          iPort_ack = ($urandom_range(99) < pa);
      @(negedge iClk);
      check_cycle();
      model_step();
      @(posedge iClk);
      #1;
    end
  endtask

  initial begin
    iRstn             = 1'b0;
    arbOut_portTx_vld = 1'b0;
    arbOut_portTx_pkt = '0;
    iPort_ack         = 1'b0;
    model_reset();
    repeat (3) @(posedge iClk);
    #1;
    check_eq("rst_vld", oPort_vld, 1'b0);
    check_eq("rst_pkt", oPort_pkt, '0);
    check_eq("rst_err", oTmoErr, 1'b0);
    check_eq("rst_cnt", oFifoCnt, '0);
    iRstn = 1'b1;

    run(8, 0, 50, 1'b0);      // stray acks while idle
    run(1, 100, 0, 1'b0);     // single packet, then ack a few cycles later
    run(3, 0, 0, 1'b0);
    run(3, 0, 100, 1'b0);
    run(4, 100, 100, 1'b0);   // back-to-back burst
    run(8, 0, 100, 1'b0);
    run(12, 100, 0, 1'b0);    // fill to full, first timeout
    run(40, 60, 0, 1'b1);     // ack exactly on the terminal timeout cycle
    run(40, 50, 0, 1'b0);     // repeated timeouts
    run(200, 50, 60, 1'b0);
    run(200, 90, 90, 1'b0);
    run(100, 30, 20, 1'b0);

    // Reset with a packet on the wire and at least three queued.
    run(20, 0, 100, 1'b0);
    run(5, 100, 0, 1'b0);
    #3;
    iRstn = 1'b0;
    #1;
    check_eq("midrst_vld", oPort_vld, 1'b0);
    check_eq("midrst_pkt", oPort_pkt, '0);
    check_eq("midrst_err", oTmoErr, 1'b0);
    check_eq("midrst_cnt", oFifoCnt, '0);
    check_eq("midrst_ack", portTx_arbOut_ack, arbOut_portTx_vld);
    model_reset();
    arbOut_portTx_vld = 1'b0;
    iPort_ack         = 1'b0;
    repeat (2) @(posedge iClk);
    #1;
    iRstn = 1'b1;

    run(6, 0, 50, 1'b0);      // nothing stale may reappear
    run(150, 70, 70, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
